// File: rtl/axi_lite_counter_slave.sv
// AXI4-Lite slave holding a 32-bit up-counter with limit compare, sticky
// terminal-count status and a level interrupt.
// Register map (byte address, bits [3:2]):
//   0x0 CTRL   : [0] EN, [1] CLR (write-1 pulse, reads 0), [2] AUTO_RELOAD, [3] IRQ_EN
//   0x4 LIMIT  : terminal-count compare value
//   0x8 COUNT  : live counter, writes load it
//   0xC STATUS : [0] TC, sticky, write-1-to-clear
module axi_lite_counter_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                              ACLK,
   input  logic                              ARESETN,
   // write address channel
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     AWADDR,
   input  logic [2:0]                        AWPROT,
   input  logic                              AWVALID,
   output logic                              AWREADY,
   // write data channel
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   WSTRB,
   input  logic                              WVALID,
   output logic                              WREADY,
   // write response channel
   output logic [1:0]                        BRESP,
   output logic                              BVALID,
   input  logic                              BREADY,
   // read address channel
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     ARADDR,
   input  logic [2:0]                        ARPROT,
   input  logic                              ARVALID,
   output logic                              ARREADY,
   // read data channel
   output logic [C_S_AXI_DATA_WIDTH-1:0]     RDATA,
   output logic [1:0]                        RRESP,
   output logic                              RVALID,
   input  logic                              RREADY,
   // counter events
   output logic                              tc_pulse,
   output logic                              irq
);

   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int SW = C_S_AXI_DATA_WIDTH / 8;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_LIMIT  = 2'd1;
   localparam logic [1:0] ADDR_COUNT  = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   // Byte-lane merge of write data into an existing register value.
   function automatic logic [DW-1:0] f_apply_strb(input logic [DW-1:0] old_val,
                                                  input logic [DW-1:0] new_val,
                                                  input logic [SW-1:0] strb);
      logic [DW-1:0] res;
      res = old_val;
      for (int b = 0; b < SW; b++) begin
         if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
      end
      return res;
   endfunction

   // channel state
   logic          r_awready;
   logic          r_bvalid;
   logic          r_arready;
   logic          r_rvalid;
   logic [DW-1:0] r_rdata;

   // register file
   logic          r_en;
   logic          r_auto;
   logic          r_irq_en;
   logic [DW-1:0] r_limit;
   logic [DW-1:0] r_count;
   logic          r_tc;
   // set once the counter parks at LIMIT; suppresses repeat pulses until COUNT moves
   logic          r_hold;

   logic          w_wr_go;
   logic          w_rd_go;
   logic          w_wr_ctrl;
   logic          w_wr_limit;
   logic          w_wr_count;
   logic          w_wr_status;
   logic          w_clr;
   logic          w_tc_clr;
   logic          w_tc_hit;
   logic          w_tc_pulse;
   logic [DW-1:0] w_count_nxt;
   logic [DW-1:0] w_rd_mux;
   logic          w_unused;

   // Protection bits and the byte-offset address bits carry no meaning here.
   assign w_unused = ^{AWPROT, ARPROT, AWADDR, ARADDR};

   // A write transfer happens on the edge where the one-cycle ready meets both valids.
   assign w_wr_go = r_awready & AWVALID & WVALID;
   assign w_rd_go = r_arready & ARVALID;

   assign w_wr_ctrl   = w_wr_go & (AWADDR[3:2] == ADDR_CTRL);
   assign w_wr_limit  = w_wr_go & (AWADDR[3:2] == ADDR_LIMIT);
   assign w_wr_count  = w_wr_go & (AWADDR[3:2] == ADDR_COUNT);
   assign w_wr_status = w_wr_go & (AWADDR[3:2] == ADDR_STATUS);

   assign w_clr    = w_wr_ctrl & WSTRB[0] & WDATA[1];
   assign w_tc_clr = w_wr_status & WSTRB[0] & WDATA[0];

   // Terminal count is a level condition; the pulse only fires on first arrival.
   assign w_tc_hit   = r_en & (r_count == r_limit);
   assign w_tc_pulse = w_tc_hit & ~r_hold;

   // Write address/data acceptance and response handshake.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_awready <= 1'b0;
         r_bvalid  <= 1'b0;
      end else begin
         r_awready <= ~r_awready & AWVALID & WVALID & ~r_bvalid;
         if (w_wr_go) begin
            r_bvalid <= 1'b1;
         end else if (BREADY) begin
            r_bvalid <= 1'b0;
         end
      end
   end

   // Read-back multiplexer, sampled when the read address is accepted.
   always_comb begin
      w_rd_mux = '0;
      case (ARADDR[3:2])
         ADDR_CTRL: begin
            w_rd_mux[0] = r_en;
            w_rd_mux[2] = r_auto;
            w_rd_mux[3] = r_irq_en;
         end
         ADDR_LIMIT:  w_rd_mux = r_limit;
         ADDR_COUNT:  w_rd_mux = r_count;
         ADDR_STATUS: w_rd_mux[0] = r_tc;
         default:     w_rd_mux = '0;
      endcase
   end

   // Read address acceptance and read data hold until RREADY.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
      end else begin
         r_arready <= ~r_arready & ARVALID & ~r_rvalid;
         if (w_rd_go) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_mux;
         end else if (RREADY) begin
            r_rvalid <= 1'b0;
         end
      end
   end

   // CTRL and LIMIT register writes.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_en     <= 1'b0;
         r_auto   <= 1'b0;
         r_irq_en <= 1'b0;
         r_limit  <= '1;
      end else begin
         if (w_wr_ctrl && WSTRB[0]) begin
            r_en     <= WDATA[0];
            r_auto   <= WDATA[2];
            r_irq_en <= WDATA[3];
         end
         if (w_wr_limit) begin
            r_limit <= f_apply_strb(r_limit, WDATA, WSTRB);
         end
      end
   end

   // Next counter value: clear beats load beats terminal-count handling beats increment.
   always_comb begin
      w_count_nxt = r_count;
      if (w_clr) begin
         w_count_nxt = '0;
      end else if (w_wr_count) begin
         w_count_nxt = f_apply_strb(r_count, WDATA, WSTRB);
      end else if (w_tc_hit) begin
         w_count_nxt = r_auto ? '0 : r_count;
      end else if (r_en) begin
         w_count_nxt = r_count + DW'(1);
      end
   end

   // Counter, hold flag and sticky TC; a TC set in the same cycle as its clear wins.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_count <= '0;
         r_hold  <= 1'b0;
         r_tc    <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_hold  <= ((w_tc_hit & ~r_auto) | r_hold) & (w_count_nxt == r_count);
         if (w_tc_pulse) begin
            r_tc <= 1'b1;
         end else if (w_tc_clr) begin
            r_tc <= 1'b0;
         end
      end
   end

   assign AWREADY  = r_awready;
   assign WREADY   = r_awready;
   assign BVALID   = r_bvalid;
   assign BRESP    = 2'b00;
   assign ARREADY  = r_arready;
   assign RVALID   = r_rvalid;
   assign RDATA    = r_rdata;
   assign RRESP    = 2'b00;
   assign tc_pulse = w_tc_pulse;
   assign irq      = r_tc & r_irq_en;

endmodule

// File: tb/tb_axi_lite_counter_slave.sv
// Directed bench for axi_lite_counter_slave.
module tb_axi_lite_counter_slave;

   localparam logic [3:0] A_CTRL   = 4'h0;
   localparam logic [3:0] A_LIMIT  = 4'h4;
   localparam logic [3:0] A_COUNT  = 4'h8;
   localparam logic [3:0] A_STATUS = 4'hC;

   logic        ACLK = 1'b0;
   logic        ARESETN;
   logic [3:0]  AWADDR;
   logic [2:0]  AWPROT;
   logic        AWVALID;
   logic        AWREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WVALID;
   logic        WREADY;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY;
   logic [3:0]  ARADDR;
   logic [2:0]  ARPROT;
   logic        ARVALID;
   logic        ARREADY;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RVALID;
   logic        RREADY;
   logic        tc_pulse;
   logic        irq;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always #5 ACLK = ~ACLK;

   // edge counter used to place transactions on the counter timeline
   always @(posedge ACLK) cyc <= cyc + 1;

   axi_lite_counter_slave #(
      .C_S_AXI_DATA_WIDTH(32),
      .C_S_AXI_ADDR_WIDTH(4)
   ) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
      .tc_pulse(tc_pulse), .irq(irq)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Present AW and W together, return the edge index of the handshake.
   task automatic wr_issue(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           output int hs);
      logic ok;
      ok = 1'b0;
      @(posedge ACLK); #1;
      AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge ACLK);
         if (AWREADY === 1'b1 && WREADY === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      chk1("wr_accept", ok, 1'b1);
      @(posedge ACLK); #1;
      hs = cyc;
      AWVALID = 1'b0; WVALID = 1'b0;
   endtask

   task automatic wr_finish();
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge ACLK);
         if (BVALID === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      chk1("bvalid", ok, 1'b1);
      chk("bresp", {30'b0, BRESP}, 32'h0);
      @(posedge ACLK); #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      int hs;
      wr_issue(a, d, s, hs);
      wr_finish();
   endtask

   task automatic rd(input logic [3:0] a, output logic [31:0] data, output int hs);
      logic ok;
      ok = 1'b0;
      data = 32'hDEAD_BEEF;
      @(posedge ACLK); #1;
      ARADDR = a; ARVALID = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge ACLK);
         if (ARREADY === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      chk1("ar_accept", ok, 1'b1);
      @(posedge ACLK); #1;
      hs = cyc;
      ARVALID = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge ACLK);
         if (RVALID === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      chk1("rvalid", ok, 1'b1);
      data = RDATA;
      chk("rresp", {30'b0, RRESP}, 32'h0);
      @(posedge ACLK); #1;
   endtask

   task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
      logic [31:0] d;
      int hs;
      rd(a, d, hs);
      chk(tag, d, exp);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk1({tag, "_awready"}, AWREADY, 1'b0);
      chk1({tag, "_wready"},  WREADY,  1'b0);
      chk1({tag, "_arready"}, ARREADY, 1'b0);
      chk1({tag, "_bvalid"},  BVALID,  1'b0);
      chk1({tag, "_rvalid"},  RVALID,  1'b0);
      chk({tag, "_bresp"}, {30'b0, BRESP}, 32'h0);
      chk({tag, "_rresp"}, {30'b0, RRESP}, 32'h0);
      chk({tag, "_rdata"}, RDATA, 32'h0);
      chk1({tag, "_tc_pulse"}, tc_pulse, 1'b0);
      chk1({tag, "_irq"}, irq, 1'b0);
   endtask

   logic [31:0] d;
   int          hsw;
   int          hsr;
   int          n;
   logic        ok;

   initial begin
      ARESETN = 1'b0;
      AWADDR = '0; AWPROT = 3'b0; AWVALID = 1'b0;
      WDATA = '0; WSTRB = '0; WVALID = 1'b0;
      BREADY = 1'b1;
      ARADDR = '0; ARPROT = 3'b0; ARVALID = 1'b0;
      RREADY = 1'b1;

      // reset values, then register defaults after release
      repeat (2) @(posedge ACLK);
      @(negedge ACLK);
      chk_reset_outputs("por");
      ARESETN = 1'b1;
      rd_chk("rst_ctrl",   A_CTRL,   32'h0000_0000);
      rd_chk("rst_limit",  A_LIMIT,  32'hFFFF_FFFF);
      rd_chk("rst_count",  A_COUNT,  32'h0000_0000);
      rd_chk("rst_status", A_STATUS, 32'h0000_0000);

      // LIMIT=3, EN+AUTO_RELOAD: count 0,1,2,3,0,... with a pulse at 3
      wr(A_LIMIT, 32'd3, 4'hF);
      wr_issue(A_CTRL, 32'h5, 4'hF, hsw);
      for (int i = 0; i < 8; i++) begin
         @(negedge ACLK);
         if (i == 0) chk1("ctrl_bvalid", BVALID, 1'b1);
         chk1($sformatf("reload_pulse_%0d", i), tc_pulse, ((i % 4) == 3));
      end
      rd(A_COUNT, d, hsr);
      chk("reload_count", d, 32'((hsr - hsw - 1) % 4));
      rd_chk("reload_status", A_STATUS, 32'h1);
      rd_chk("reload_ctrl",   A_CTRL,   32'h5);

      // stop and clear, then W1C the sticky flag
      wr(A_CTRL, 32'h2, 4'h1);
      rd_chk("clr_ctrl",  A_CTRL,  32'h0);
      rd_chk("clr_count", A_COUNT, 32'h0);
      wr(A_STATUS, 32'h1, 4'h1);
      rd_chk("w1c_status", A_STATUS, 32'h0);

      // byte-strobed COUNT loads while stopped
      wr(A_COUNT, 32'h0000_1234, 4'hF);
      wr(A_COUNT, 32'h0000_00AA, 4'h1);
      rd_chk("strb_lane0", A_COUNT, 32'h0000_12AA);
      wr(A_COUNT, 32'h0055_0000, 4'h4);
      rd_chk("strb_lane2", A_COUNT, 32'h0055_12AA);

      // CTRL upper bits read as zero; CLR bit never reads back
      wr(A_CTRL, 32'hFFFF_FFF8, 4'hF);
      rd_chk("ctrl_upper", A_CTRL, 32'h8);
      chk1("irq_no_tc", irq, 1'b0);
      wr(A_CTRL, 32'h0, 4'hF);

      // 32-bit wrap below LIMIT, then hold at LIMIT=5 without reload
      wr(A_LIMIT, 32'd5, 4'hF);
      wr(A_COUNT, 32'hFFFF_FFFE, 4'hF);
      wr_issue(A_CTRL, 32'h1, 4'hF, hsw);
      wr_finish();
      rd(A_COUNT, d, hsr);
      n = hsr - hsw - 1;
      chk("wrap_count", d, (n >= 7) ? 32'd5 : 32'(32'hFFFF_FFFE + 32'(n)));
      wr(A_CTRL, 32'h2, 4'h1);
      wr(A_STATUS, 32'h1, 4'h1);

      // AW before W, BREADY held low, a queued second write
      BREADY = 1'b0;
      @(posedge ACLK); #1;
      AWADDR = A_LIMIT; WDATA = 32'h1111_1111; WSTRB = 4'hF; AWVALID = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge ACLK);
         chk1("aw_only_awready", AWREADY, 1'b0);
         chk1("aw_only_wready",  WREADY,  1'b0);
      end
      @(posedge ACLK); #1;
      WVALID = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge ACLK);
         if (AWREADY === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      chk1("joint_accept", ok, 1'b1);
      chk1("joint_wready", WREADY, 1'b1);
      @(posedge ACLK); #1;
      AWADDR = A_COUNT; WDATA = 32'h0000_0022;
      for (int i = 0; i < 5; i++) begin
         @(negedge ACLK);
         chk1("bvalid_hold", BVALID, 1'b1);
         chk1("no_second_accept", AWREADY, 1'b0);
      end
      BREADY = 1'b1;
      @(posedge ACLK); #1;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge ACLK);
         if (AWREADY === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      chk1("second_accept", ok, 1'b1);
      @(posedge ACLK); #1;
      AWVALID = 1'b0; WVALID = 1'b0;
      @(negedge ACLK);
      chk1("second_bvalid", BVALID, 1'b1);
      @(posedge ACLK); #1;
      rd_chk("queued_limit", A_LIMIT, 32'h1111_1111);
      rd_chk("queued_count", A_COUNT, 32'h0000_0022);

      // EN+IRQ_EN without reload: park at LIMIT=2, irq level, W1C drops it
      wr(A_LIMIT, 32'd2, 4'hF);
      wr(A_CTRL, 32'h2, 4'h1);
      wr(A_CTRL, 32'h9, 4'hF);
      repeat (6) @(negedge ACLK);
      chk1("hold_irq", irq, 1'b1);
      chk1("hold_no_repulse", tc_pulse, 1'b0);
      rd_chk("hold_count",  A_COUNT,  32'd2);
      rd_chk("hold_status", A_STATUS, 32'h1);
      wr(A_STATUS, 32'h1, 4'h1);
      @(negedge ACLK);
      chk1("w1c_irq", irq, 1'b0);
      rd_chk("w1c_hold_status", A_STATUS, 32'h0);

      // LIMIT=0 with reload: pulse every cycle; W1C during a pulse loses
      wr(A_CTRL, 32'h2, 4'h1);
      wr(A_LIMIT, 32'd0, 4'hF);
      wr(A_CTRL, 32'hD, 4'hF);
      for (int i = 0; i < 4; i++) begin
         @(negedge ACLK);
         chk1("limit0_pulse", tc_pulse, 1'b1);
      end
      wr(A_STATUS, 32'h1, 4'h1);
      rd_chk("set_wins_status", A_STATUS, 32'h1);
      chk1("set_wins_irq", irq, 1'b1);

      // asynchronous reset with read and write responses pending
      RREADY = 1'b0;
      @(posedge ACLK); #1;
      ARADDR = A_CTRL; ARVALID = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge ACLK);
         if (RVALID === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      chk1("pend_rvalid", ok, 1'b1);
      ARVALID = 1'b0;
      chk("pend_rdata", RDATA, 32'hD);
      BREADY = 1'b0;
      wr_issue(A_LIMIT, 32'd0, 4'hF, hsw);
      @(negedge ACLK);
      chk1("pend_bvalid", BVALID, 1'b1);
      chk1("pend_rvalid_hold", RVALID, 1'b1);
      chk1("pend_pulse", tc_pulse, 1'b1);
      chk1("pend_irq", irq, 1'b1);
      #2;
      ARESETN = 1'b0;
      #1;
      chk_reset_outputs("async");
      BREADY = 1'b1; RREADY = 1'b1;
      repeat (2) @(posedge ACLK);
      @(negedge ACLK);
      ARESETN = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge ACLK);
         chk1("post_rst_bvalid", BVALID, 1'b0);
         chk1("post_rst_rvalid", RVALID, 1'b0);
      end
      rd_chk("post_rst_ctrl",   A_CTRL,   32'h0000_0000);
      rd_chk("post_rst_limit",  A_LIMIT,  32'hFFFF_FFFF);
      rd_chk("post_rst_count",  A_COUNT,  32'h0000_0000);
      rd_chk("post_rst_status", A_STATUS, 32'h0000_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axi_lite_counter_slave.md
AXI_LITE_COUNTER_SLAVE -- requirements
Module: axi_lite_counter_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width (4 registers).
REQ-003 SHALL have port ACLK  input  1  single clock for all logic.
REQ-004 SHALL have port ARESETN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports AWADDR in 4, AWPROT in 3 (ignored), AWVALID in 1, AWREADY out 1: write address channel.
REQ-006 SHALL have ports WDATA in 32, WSTRB in 4, WVALID in 1, WREADY out 1: write data channel.
REQ-007 SHALL have ports BRESP out 2, BVALID out 1, BREADY in 1: write response channel.
REQ-008 SHALL have ports ARADDR in 4, ARPROT in 3 (ignored), ARVALID in 1, ARREADY out 1: read address channel.
REQ-009 SHALL have ports RDATA out 32, RRESP out 2, RVALID out 1, RREADY in 1: read data channel.
REQ-010 SHALL have port tc_pulse  output  1  one-cycle pulse on terminal count.
REQ-011 SHALL have port irq  output  1  level interrupt = STATUS.TC & CTRL.IRQ_EN.

Function
REQ-012 SHALL decode registers on addr[3:2]: 0x0 CTRL, 0x4 LIMIT, 0x8 COUNT, 0xC STATUS; addr[1:0] ignored.
REQ-013 CTRL SHALL be bit0 EN, bit1 CLR (write-1 pulse, always reads 0), bit2 AUTO_RELOAD, bit3 IRQ_EN; bits 31:4 read 0.
REQ-014 LIMIT SHALL be 32-bit RW; COUNT SHALL be 32-bit, reads the live counter, writes load it; STATUS bit0 TC sticky, write-1-to-clear, bits 31:1 read 0.
REQ-015 Writes SHALL honor WSTRB per byte for CTRL, LIMIT, COUNT; STATUS W1C uses WSTRB[0] only.
REQ-016 Write accept: AWREADY and WREADY SHALL pulse high together for exactly one cycle when AWVALID & WVALID & !BVALID; register update takes effect in that same edge.
REQ-017 AW and W arriving on different cycles SHALL NOT be accepted separately; the slave waits until both are valid.
REQ-018 BVALID SHALL rise the cycle after acceptance and hold until BREADY; no new write accepted while BVALID is high.
REQ-019 Read accept: ARREADY SHALL pulse one cycle when ARVALID & !RVALID; RVALID rises next cycle with RDATA sampled at acceptance, held stable until RREADY.
REQ-020 BRESP and RRESP SHALL always be 2'b00 (OKAY); read and write channels operate independently and concurrently.
REQ-021 Counter SHALL increment by 1 per cycle while EN=1; 32-bit, wraps 0xFFFFFFFF -> 0 if LIMIT not reached.
REQ-022 When EN=1 and COUNT==LIMIT: tc_pulse=1 that cycle, TC set; next COUNT = 0 if AUTO_RELOAD else COUNT holds at LIMIT (no further tc_pulse until COUNT changes).
REQ-023 Counter update priority SHALL be: CLR write > COUNT register write > terminal-count reload/hold > increment.
REQ-024 TC set and STATUS W1C in same cycle: set SHALL win (TC=1).
REQ-025 LIMIT=0 with EN=1 and AUTO_RELOAD SHALL produce tc_pulse every cycle.
REQ-026 A read of COUNT SHALL return the value before that cycle's increment.

Reset
REQ-027 ARESETN low SHALL immediately clear: CTRL=0, LIMIT=0xFFFFFFFF, COUNT=0, TC=0, AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, tc_pulse=0, irq=0.
REQ-028 Reset mid-transaction SHALL abandon any pending response; no BVALID/RVALID after release without a new request.

Verification
REQ-029 Reset release, read 0x0/0x4/0x8/0xC -> 0x00000000, 0xFFFFFFFF, 0x00000000, 0x00000000, all RRESP=OKAY.
REQ-030 Write LIMIT=3, CTRL=0x5 -> COUNT sequence 0,1,2,3,0,1...; tc_pulse one cycle at each COUNT=3; STATUS reads 0x1.
REQ-031 EN=0, COUNT=0x00001234, write COUNT data 0x000000AA WSTRB=0x1 -> COUNT reads 0x000012AA.
REQ-032 AWVALID 3 cycles before WVALID, BREADY low 5 cycles -> AWREADY/WREADY single joint pulse when both valid; BVALID held 5 cycles; second queued write not accepted until BREADY handshake.
REQ-033 CTRL=0x9 (EN, IRQ_EN, no reload), LIMIT=2 -> COUNT holds at 2, irq=1; write STATUS 0x1 -> irq=0; W1C issued in the terminal-count cycle -> TC stays 1.
REQ-034 ARESETN asserted while counting and BVALID pending -> all outputs at REQ-027 values asynchronously, before next ACLK edge.
